cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
32-bit single-bus CPU datapath. It holds the register file R0–R15, PC, IR, MAR, MDR, HI, LO, Y, a 64-bit Z register and 32-bit ZLO/ZHI, a one-hot-selected shared bus and a 5-bit-opcode ALU. It is driven cycle-by-cycle by an external control unit (or a bench). Register contents are exported for observation.

Parameters:
WIDTH, 32, data/bus width; ALU result and Z_register are 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  synchronous active-high reset
R0in..R15in  input  1 each  register-file load enables
R0out..R15out  input  1 each  register-file bus drive enables
HIin, Loin, PCin, MARin, IRin, Yin, MDRin  input  1 each  load enables
HIout, Loout, PCout, MDRout, Yout, Cout, InPortout, ZLOout, ZHIout  input  1 each  bus drive enables
MDRread  input  1  MDR source select: 1=Mdatain, 0=bus
IncPC  input  1  PC increment
Zin, ZLOin, ZHIin  input  1 each  Z / ZLO / ZHI load enables
ZLowSelect, ZHighSelect  input  1 each  ZLO/ZHI source select
ALU_opcode  input  5  ALU operation
Mdatain  input  32  memory read data
R0..R15, HI, LO, Y, ZLO, ZHI, IR  output  32 each  register contents
BusMuxOut  output  32  current bus value
Z_register  output  64  Z register contents

Behaviour:
- Reset: clr=1 at a rising edge zeroes every register (R0–R15, PC, IR, MAR, MDR, HI, LO, Y, Z, ZLO, ZHI). Takes precedence over all enables.
- Loads: each register captures BusMuxOut on the rising edge while its *in enable is high. Otherwise it holds.
- MDR: MDRin loads Mdatain if MDRread=1, else BusMuxOut.
- PC: IncPC=1 → PC<=PC+1, with priority over PCin. PCin alone → PC<=bus.
- Bus: combinational. Sources are R0–R15, HI, LO, ZHI, ZLO, PC, MDR, Y, C, InPort.
  - Multiple drive enables high: fixed priority R0>…>R15>HI>LO>ZHI>ZLO>PC>MDR>Y>Cout>InPortout.
  - No enable high: bus = 0.
- Cout drives IR[18:0] sign-extended to 32 bits. InPortout drives 32'h0; this block has no input-port register.
- ALU: A=Y, B=BusMuxOut, combinational, 64-bit result R.
  - 00000 ADD, 00001 SUB (A-B), 00010 AND, 00011 OR, 00100 SHR, 00101 SHRA, 00110 SHL, 00111 ROR, 01000 ROL (shift amount B[4:0]), 01001 NEG (-B), 01010 NOT (~B): result in R[31:0], R[63:32]=sign-extension for ADD/SUB/NEG, else 0.
  - 01111 MUL: signed 32x32, full 64-bit product.
  - 01110 DIV: see Optional Feature.
  - Any other code: R=0.
  - ADD/SUB wrap modulo 2^32.
- Zin: Z_register<=R.
- ZLOin: ZLO<=R[31:0] if ZLowSelect, else Z_register[31:0].
- ZHIin: ZHI<=R[63:32] if ZHighSelect, else Z_register[63:32].
- Same-edge conflicts: every register samples the pre-edge bus, so a register-to-register transfer in one cycle is legal. Z and ZLO/ZHI loaded in the same cycle with select=0 take the old Z.
- MAR is internal and not exported.

Optional Feature:
DIV_EN: when defined, opcode 01110 is signed division of Y by bus (R[31:0]=quotient, R[63:32]=remainder, truncated toward zero). Divisor 0 gives R=0. When not defined, 01110 gives R=0 and no divider logic is synthesised.

Test Plan:
- MDR path: Mdatain=0x0000000F, MDRread=1, MDRin=1 for one edge; then MDRout=1, R0in=1 for one edge → R0=0x0000000F, BusMuxOut=0x0000000F during the transfer.
- Multiply: R4=0x4, R5=0x12; R4out+Yin (Y=4); then ALU_opcode=01111, R5out, Zin, ZLOin, ZLowSelect; then ZHIin, ZHighSelect; ZLOout+Loin; ZHIout+HIin → Z_register=0x48, ZLO=0x48, ZHI=0, LO=0x48, HI=0.
- Signed multiply: Y=0xFFFFFFFF, bus=2, opcode 01111, Zin → Z_register=0xFFFFFFFFFFFFFFFE.
- Reset: load R7=0x1234, PC=5; assert clr one edge with R7in=1, bus=0xAA → all outputs 0. Deasserting clr between edges changes nothing until the next edge.
- Bus/PC: R1out and R2out both high → bus=R1. No enables → bus=0. IncPC with PCin → PC increments (PC=5→6).
- DIV_EN defined: Y=0xFFFFFFF9 (-7), bus=2, opcode 01110 → R[31:0]=0xFFFFFFFD, R[63:32]=0xFFFFFFFF. Not defined → R=0.

Source files
------------

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, priority bus mux and ALU.
// Optional build macro DIV_EN adds signed division on opcode 01110.
module cpu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             HIin, Loin, PCin, MARin, IRin, Yin, MDRin,
    input  logic             HIout, Loout, PCout, MDRout, Yout, Cout, InPortout, ZLOout, ZHIout,
    input  logic             MDRread,
    input  logic             IncPC,
    input  logic             Zin, ZLOin, ZHIin,
    input  logic             ZLowSelect, ZHighSelect,
    input  logic [4:0]       ALU_opcode,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [WIDTH-1:0] R8, R9, R10, R11, R12, R13, R14, R15,
    output logic [WIDTH-1:0] HI, LO, Y, ZLO, ZHI, IR,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [2*WIDTH-1:0] Z_register
);

    localparam int IMM_W = 19;
    localparam int SH_W  = $clog2(WIDTH);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_AND  = 5'b00010,
        OP_OR   = 5'b00011,
        OP_SHR  = 5'b00100,
        OP_SHRA = 5'b00101,
        OP_SHL  = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_NEG  = 5'b01001,
        OP_NOT  = 5'b01010,
        OP_DIV  = 5'b01110,
        OP_MUL  = 5'b01111
    } alu_op_e;

    logic [15:0]          rin, rout;
    logic [WIDTH-1:0]     rf_q [16];
    logic [WIDTH-1:0]     rf_d [16];
    logic [WIDTH-1:0]     pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, y_q, y_d, zlo_q, zlo_d, zhi_q, zhi_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic [WIDTH-1:0]     bus, c_sext;
    logic [2*WIDTH-1:0]   alu_r;

    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    assign c_sext = {{(WIDTH-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    // Special sources resolved first; the register-file scan then runs R15 down to R0
    // so the lowest-numbered active register overrides everything else.
    always_comb begin
        logic [3:0] idx;
        idx = '0;
        bus = '0;
        if (HIout)          bus = hi_q;
        else if (Loout)     bus = lo_q;
        else if (ZHIout)    bus = zhi_q;
        else if (ZLOout)    bus = zlo_q;
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (Yout)      bus = y_q;
        else if (Cout)      bus = c_sext;
        else if (InPortout) bus = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            idx = 4'(15 - k);
            if (rout[idx]) bus = rf_q[idx];
        end
    end

    always_comb begin
        logic [WIDTH-1:0]   a, b, res;
        logic [SH_W-1:0]    sh;
        logic [2*WIDTH-1:0] rot, a_ext, b_ext;
        logic               ext, wide;
        a     = y_q;
        b     = bus;
        sh    = b[SH_W-1:0];
        res   = '0;
        rot   = '0;
        ext   = 1'b0;
        wide  = 1'b0;
        alu_r = '0;
        a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        case (alu_op_e'(ALU_opcode))
            OP_ADD:  begin res = a + b; ext = 1'b1; end
            OP_SUB:  begin res = a - b; ext = 1'b1; end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SHR:  res = a >> sh;
            OP_SHRA: res = WIDTH'($signed(a) >>> sh);
            OP_SHL:  res = a << sh;
            OP_ROR:  begin rot = {a, a} >> sh; res = rot[WIDTH-1:0]; end
            OP_ROL:  begin rot = {a, a} << sh; res = rot[2*WIDTH-1:WIDTH]; end
            OP_NEG:  begin res = '0 - b; ext = 1'b1; end
            OP_NOT:  res = ~b;
            OP_MUL:  begin wide = 1'b1; alu_r = a_ext * b_ext; end
`ifdef DIV_EN
            OP_DIV:  begin
                wide = 1'b1;
                if (b != '0)
                    alu_r = {WIDTH'($signed(a) % $signed(b)), WIDTH'($signed(a) / $signed(b))};
            end
`endif
            default: wide = 1'b1;
        endcase
        if (!wide) alu_r = {{WIDTH{ext & res[WIDTH-1]}}, res};
    end

    always_comb begin
        for (int unsigned k = 0; k < 16; k++)
            rf_d[k] = rin[4'(k)] ? bus : rf_q[k];
        pc_d = pc_q;
        if (IncPC)     pc_d = pc_q + WIDTH'(1);
        else if (PCin) pc_d = bus;
        ir_d  = IRin  ? bus : ir_q;
        mar_d = MARin ? bus : mar_q;
        mdr_d = MDRin ? (MDRread ? Mdatain : bus) : mdr_q;
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = Loin  ? bus : lo_q;
        y_d   = Yin   ? bus : y_q;
        z_d   = Zin   ? alu_r : z_q;
        // Select=0 paths read z_q, i.e. the Z value from before this edge.
        zlo_d = ZLOin ? (ZLowSelect  ? alu_r[WIDTH-1:0]       : z_q[WIDTH-1:0])       : zlo_q;
        zhi_d = ZHIin ? (ZHighSelect ? alu_r[2*WIDTH-1:WIDTH] : z_q[2*WIDTH-1:WIDTH]) : zhi_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned k = 0; k < 16; k++) rf_q[k] <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            zlo_q <= '0;
            zhi_q <= '0;
        end else begin
            rf_q  <= rf_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            y_q   <= y_d;
            z_q   <= z_d;
            zlo_q <= zlo_d;
            zhi_q <= zhi_d;
        end
    end

    assign R0  = rf_q[0];
    assign R1  = rf_q[1];
    assign R2  = rf_q[2];
    assign R3  = rf_q[3];
    assign R4  = rf_q[4];
    assign R5  = rf_q[5];
    assign R6  = rf_q[6];
    assign R7  = rf_q[7];
    assign R8  = rf_q[8];
    assign R9  = rf_q[9];
    assign R10 = rf_q[10];
    assign R11 = rf_q[11];
    assign R12 = rf_q[12];
    assign R13 = rf_q[13];
    assign R14 = rf_q[14];
    assign R15 = rf_q[15];
    assign HI  = hi_q;
    assign LO  = lo_q;
    assign Y   = y_q;
    assign ZLO = zlo_q;
    assign ZHI = zhi_q;
    assign IR  = ir_q;
    assign BusMuxOut  = bus;
    assign Z_register = z_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: stimulus queues expected values, a negedge monitor checks them.
module tb_cpu_datapath;

    localparam int SEL_HI = 16, SEL_LO = 17, SEL_Y = 18, SEL_ZLO = 19, SEL_ZHI = 20;
    localparam int SEL_IR = 21, SEL_BUS = 22, SEL_Z = 23;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR = 5'b00011, OP_SHR = 5'b00100, OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000;
    localparam logic [4:0] OP_NEG = 5'b01001, OP_NOT = 5'b01010, OP_DIV = 5'b01110;
    localparam logic [4:0] OP_MUL = 5'b01111;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] rin, rout;
    logic        HIin, Loin, PCin, MARin, IRin, Yin, MDRin;
    logic        HIout, Loout, PCout, MDRout, Yout, Cout, InPortout, ZLOout, ZHIout;
    logic        MDRread, IncPC, Zin, ZLOin, ZHIin, ZLowSelect, ZHighSelect;
    logic [4:0]  ALU_opcode;
    logic [31:0] Mdatain;
    logic [31:0] r [16];
    logic [31:0] HI, LO, Y, ZLO, ZHI, IR, BusMuxOut;
    logic [63:0] Z_register;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cpu_datapath #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIin(HIin), .Loin(Loin), .PCin(PCin), .MARin(MARin), .IRin(IRin), .Yin(Yin), .MDRin(MDRin),
        .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .Yout(Yout), .Cout(Cout),
        .InPortout(InPortout), .ZLOout(ZLOout), .ZHIout(ZHIout),
        .MDRread(MDRread), .IncPC(IncPC), .Zin(Zin), .ZLOin(ZLOin), .ZHIin(ZHIin),
        .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect), .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
        .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]), .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
        .R8(r[8]), .R9(r[9]), .R10(r[10]), .R11(r[11]), .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
        .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI), .IR(IR),
        .BusMuxOut(BusMuxOut), .Z_register(Z_register)
    );

    function automatic logic [63:0] observe(int sel);
        if (sel < 16) return {32'h0, r[sel]};
        case (sel)
            SEL_HI:  return {32'h0, HI};
            SEL_LO:  return {32'h0, LO};
            SEL_Y:   return {32'h0, Y};
            SEL_ZLO: return {32'h0, ZLO};
            SEL_ZHI: return {32'h0, ZHI};
            SEL_IR:  return {32'h0, IR};
            SEL_BUS: return {32'h0, BusMuxOut};
            default: return Z_register;
        endcase
    endfunction

    // Monitor: every queued expectation is checked at the next falling edge.
    initial begin
        chk_t        c;
        logic [63:0] got;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                c   = sbq.pop_front();
                got = observe(c.sel);
                vectors++;
                if (got !== c.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [63:0] v);
        chk_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic idle();
        rin = '0; rout = '0;
        HIin = 0; Loin = 0; PCin = 0; MARin = 0; IRin = 0; Yin = 0; MDRin = 0;
        HIout = 0; Loout = 0; PCout = 0; MDRout = 0; Yout = 0; Cout = 0; InPortout = 0;
        ZLOout = 0; ZHIout = 0; MDRread = 0; IncPC = 0; Zin = 0; ZLOin = 0; ZHIin = 0;
        ZLowSelect = 0; ZHighSelect = 0; ALU_opcode = '0; Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; MDRread = 1; MDRin = 1;
        tick();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; rin[idx] = 1;
        tick();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_reg(8, v);
        rout[8] = 1; Yin = 1;
        tick();
        expect_val("y_load", SEL_Y, {32'h0, v});
    endtask

    task automatic alu_z(input string name, input logic [4:0] op, input logic [31:0] b,
                         input logic [63:0] exp);
        load_reg(9, b);
        ALU_opcode = op; rout[9] = 1; Zin = 1;
        tick();
        expect_val(name, SEL_Z, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        clr = 1;
        tick();
        tick();
        clr = 0;
        for (int i = 0; i < 16; i++) expect_val($sformatf("reset_r%0d", i), i, 64'h0);
        expect_val("reset_hi", SEL_HI, 64'h0);
        expect_val("reset_lo", SEL_LO, 64'h0);
        expect_val("reset_y", SEL_Y, 64'h0);
        expect_val("reset_zlo", SEL_ZLO, 64'h0);
        expect_val("reset_zhi", SEL_ZHI, 64'h0);
        expect_val("reset_ir", SEL_IR, 64'h0);
        expect_val("reset_z", SEL_Z, 64'h0);
        expect_val("reset_bus_idle", SEL_BUS, 64'h0);
        tick();

        // MDR path from memory into R0
        load_mdr(32'h0000000F);
        MDRout = 1; rin[0] = 1;
        expect_val("mdr_bus", SEL_BUS, 64'hF);
        tick();
        expect_val("mdr_r0", 0, 64'hF);

        // Multiply 4 x 0x12 through Z/ZLO/ZHI into LO/HI
        load_reg(4, 32'h4);
        load_reg(5, 32'h12);
        rout[4] = 1; Yin = 1;
        tick();
        expect_val("mul_y", SEL_Y, 64'h4);
        rout[5] = 1; HIin = 1;
        tick();
        expect_val("hi_preload", SEL_HI, 64'h12);
        ALU_opcode = OP_MUL; rout[5] = 1; Zin = 1; ZLOin = 1; ZLowSelect = 1;
        tick();
        expect_val("mul_z", SEL_Z, 64'h48);
        expect_val("mul_zlo", SEL_ZLO, 64'h48);
        ALU_opcode = OP_MUL; rout[5] = 1; ZHIin = 1; ZHighSelect = 1;
        tick();
        expect_val("mul_zhi", SEL_ZHI, 64'h0);
        ZLOout = 1; Loin = 1;
        expect_val("zlo_bus", SEL_BUS, 64'h48);
        tick();
        expect_val("mul_lo", SEL_LO, 64'h48);
        ZHIout = 1; HIin = 1;
        tick();
        expect_val("mul_hi", SEL_HI, 64'h0);

        // Z and ZLO/ZHI on the same edge with select=0 take the old Z
        ALU_opcode = OP_ADD; rout[5] = 1; Zin = 1; ZLOin = 1; ZHIin = 1;
        tick();
        expect_val("sameedge_z", SEL_Z, 64'h16);
        expect_val("sameedge_zlo_old", SEL_ZLO, 64'h48);
        ZLOin = 1;
        tick();
        expect_val("zlo_from_z", SEL_ZLO, 64'h16);

        set_y(32'hFFFFFFFF);
        alu_z("mul_signed", OP_MUL, 32'h2, 64'hFFFFFFFF_FFFFFFFE);

        set_y(32'h80000001);
        alu_z("add_wrap", OP_ADD, 32'h80000000, 64'h00000000_00000001);
        alu_z("add_sext", OP_ADD, 32'h1, 64'hFFFFFFFF_80000002);
        alu_z("sub", OP_SUB, 32'h2, 64'h00000000_7FFFFFFF);
        alu_z("sub_zero", OP_SUB, 32'h80000001, 64'h0);
        alu_z("and", OP_AND, 32'hF000000F, 64'h00000000_80000001);
        alu_z("or", OP_OR, 32'h0000FF00, 64'h00000000_8000FF01);
        alu_z("shr", OP_SHR, 32'h4, 64'h00000000_08000000);
        alu_z("shra", OP_SHRA, 32'h4, 64'h00000000_F8000000);
        alu_z("shra_amt5", OP_SHRA, 32'h21, 64'h00000000_C0000000);
        alu_z("shl", OP_SHL, 32'h1, 64'h00000000_00000002);
        alu_z("shl31", OP_SHL, 32'd31, 64'h00000000_80000000);
        alu_z("ror", OP_ROR, 32'h1, 64'h00000000_C0000000);
        alu_z("rol", OP_ROL, 32'h1, 64'h00000000_00000003);
        alu_z("bad_op_1f", 5'b11111, 32'h1, 64'h0);
        alu_z("rol_amt0", OP_ROL, 32'd32, 64'h00000000_80000001);
        alu_z("neg", OP_NEG, 32'h5, 64'hFFFFFFFF_FFFFFFFB);
        alu_z("neg_zero", OP_NEG, 32'h0, 64'h0);
        alu_z("not", OP_NOT, 32'h0F0F0F0F, 64'h00000000_F0F0F0F0);
        alu_z("bad_op_0b", 5'b01011, 32'h1, 64'h0);
        alu_z("mul_neg", OP_MUL, 32'h2, 64'hFFFFFFFF_00000002);

        set_y(32'hFFFFFFF9);
`ifdef DIV_EN
        alu_z("div", OP_DIV, 32'h2, 64'hFFFFFFFF_FFFFFFFD);
`else
        alu_z("div_absent", OP_DIV, 32'h2, 64'h0);
`endif
        alu_z("add_neg", OP_ADD, 32'h2, 64'hFFFFFFFF_FFFFFFFB);
        alu_z("div_by_zero", OP_DIV, 32'h0, 64'h0);

        // IR immediate, sign-extended from bit 18
        load_mdr(32'hABC40001);
        MDRout = 1; IRin = 1;
        tick();
        expect_val("ir_load", SEL_IR, 64'hABC40001);
        Cout = 1;
        expect_val("c_sext_neg", SEL_BUS, 64'hFFFC0001);
        tick();
        Cout = 1; InPortout = 1;
        expect_val("c_over_inport", SEL_BUS, 64'hFFFC0001);
        tick();
        InPortout = 1;
        expect_val("inport_zero", SEL_BUS, 64'h0);
        tick();
        load_mdr(32'hFFF3FFFF);
        MDRout = 1; IRin = 1;
        tick();
        Cout = 1;
        expect_val("c_sext_pos", SEL_BUS, 64'h0003FFFF);
        tick();

        // Bus priority
        load_reg(1, 32'h11);
        load_reg(2, 32'h22);
        load_reg(15, 32'h55);
        rout[1] = 1; rout[2] = 1;
        expect_val("bus_r1_over_r2", SEL_BUS, 64'h11);
        tick();
        rout[2] = 1; Yout = 1;
        expect_val("bus_r2_over_y", SEL_BUS, 64'h22);
        tick();
        rout[15] = 1; HIout = 1;
        expect_val("bus_r15_over_hi", SEL_BUS, 64'h55);
        tick();
        expect_val("bus_none", SEL_BUS, 64'h0);
        tick();

        // PC load, increment priority over PCin
        load_mdr(32'h5);
        MDRout = 1; PCin = 1;
        tick();
        PCout = 1;
        expect_val("pc_load", SEL_BUS, 64'h5);
        tick();
        IncPC = 1; PCin = 1; rout[1] = 1;
        tick();
        PCout = 1;
        expect_val("pc_inc_priority", SEL_BUS, 64'h6);
        tick();
        PCin = 1; rout[2] = 1;
        tick();
        PCout = 1;
        expect_val("pc_from_bus", SEL_BUS, 64'h22);
        tick();
        IncPC = 1;
        tick();
        PCout = 1;
        expect_val("pc_inc", SEL_BUS, 64'h23);
        tick();

        // Reset overrides a simultaneous load
        load_reg(7, 32'h1234);
        load_reg(3, 32'hAA);
        load_mdr(32'h5);
        MDRout = 1; PCin = 1;
        tick();
        clr = 1; rin[7] = 1; rout[3] = 1;
        expect_val("pre_reset_r7", 7, 64'h1234);
        expect_val("pre_reset_bus", SEL_BUS, 64'hAA);
        tick();
        clr = 0;
        expect_val("clr_r7", 7, 64'h0);
        expect_val("clr_r3", 3, 64'h0);
        expect_val("clr_r15", 15, 64'h0);
        expect_val("clr_y", SEL_Y, 64'h0);
        expect_val("clr_z", SEL_Z, 64'h0);
        expect_val("clr_zlo", SEL_ZLO, 64'h0);
        expect_val("clr_lo", SEL_LO, 64'h0);
        expect_val("clr_ir", SEL_IR, 64'h0);
        PCout = 1;
        expect_val("clr_pc", SEL_BUS, 64'h0);
        tick();
        MDRout = 1;
        expect_val("clr_mdr", SEL_BUS, 64'h0);
        tick();

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
